mbus_arbiter: RTL

//  Two-master Wishbone-classic arbiter for the memory bus. Sits between the masters (m0 = BIU memory port,
//  m1 = second bus master, e.g. DMA/display fetch) and the master port of the memory bus switch.

---
 rtl/mbus_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mbus_arbiter.sv
// rtl/mbus_arbiter.sv - two-master Wishbone-classic memory bus arbiter with watchdog abort
// Grant is held in registered FSM state; all outputs are muxes selected by that state.
module mbus_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WD_MAX  = '1;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] wd_q, wd_d;

  logic granted;
  logic sel_m1;
  logic cur_stb;
  logic expire;
  logic wd_err;

  always_comb begin
    granted = (state_q != IDLE);
    sel_m1  = (state_q == GNT1);
    cur_stb = sel_m1 ? m1_stb_i : m0_stb_i;
    expire  = granted && (wd_q == WD_LAST);
    wd_err  = expire && cur_stb && !s_ack_i;
  end

  always_comb begin
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (granted) begin
      // The expiring cycle withdraws the strobe so the slave sees the abort.
      s_stb_o = cur_stb && !expire;
      s_we_o  = sel_m1 ? m1_we_i  : m0_we_i;
      s_adr_o = sel_m1 ? m1_adr_i : m0_adr_i;
      s_dat_o = sel_m1 ? m1_dat_i : m0_dat_i;
      s_sel_o = sel_m1 ? m1_sel_i : m0_sel_i;
      if (sel_m1) begin
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = wd_err;
      end else begin
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = wd_err;
      end
    end
  end

  assign gnt_o = state_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (m0_stb_i && m1_stb_i) begin
          state_d = ((FIXED_PRIO != 0) || !rr_q) ? GNT0 : GNT1;
        end else if (m0_stb_i) begin
          state_d = GNT0;
        end else if (m1_stb_i) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (s_ack_i) begin
          state_d = IDLE;
          rr_d    = !sel_m1;
        end else if (!cur_stb) begin
          state_d = IDLE;
        end else if (expire) begin
          state_d = IDLE;
          rr_d    = !sel_m1;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
    end
  end

endmodule
